clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel, runtime-programmable clock divider: the parametrised successor of the fixed-divisor single-output divider. Each of NCH channels divides `clock_in` by its own divisor with a programmable high time, a per-channel enable and a one-cycle period-start tick. New settings load through a valid/ready config port and take effect only at a period boundary, so outputs never glitch. It sits between the board clock and the game/VGA timing logic, e.g. paddle/ball update rates and blink rates.

## Interface
- `NCH`, 2: number of channels (1..8)
- `W`, 28: counter, divisor and high-time width
- `CHW`, 3: width of `cfg_ch`
- `DEF_DIV`, 1000000: divisor of every channel after reset
- `DEF_HIGH`, 500000: high time of every channel after reset (must satisfy 1 ≤ DEF_HIGH < DEF_DIV)

- `clock_in`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  NCH  per-channel run enable
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  config accepted when `cfg_valid & cfg_ready`
- `cfg_ch`  in  CHW  target channel
- `cfg_div`  in  W  new divisor (period in `clock_in` cycles)
- `cfg_high`  in  W  new high time in cycles
- `cfg_err`  out  1  one-cycle pulse: request rejected
- `clock_out`  out  NCH  divided clocks, registered
- `tick`  out  NCH  one-cycle pulse at each period start, registered

## Operation
- Reset (async, `rst_n`=0): every `cnt`=0, `div_act`=DEF_DIV, `high_act`=DEF_HIGH, `pending`=0, `clock_out`=0, `tick`=0, `cfg_err`=0. `cfg_ready` is combinational and therefore 1 after reset.
- Channel enabled, per clock: `clock_out[i] <= (cnt < high_act)`, `tick[i] <= (cnt == 0)`, then `cnt <= (cnt == div_act-1) ? 0 : cnt+1`. All comparisons are unsigned W-bit.
- Channel disabled: `cnt` is forced to 0, `clock_out[i] <= 0`, `tick[i] <= 0`.
- Config validation happens on the accept cycle. The request is rejected if `cfg_ch ≥ NCH`, `cfg_div < 2`, `cfg_high == 0` or `cfg_high ≥ cfg_div`.
  - Rejected: `cfg_err <= 1` for one cycle; nothing is stored.
  - Valid: `shadow_div`/`shadow_high` of the channel are written and `pending[ch] <= 1`.
- `cfg_ready = !pending[cfg_ch]` for in-range `cfg_ch`, and 1 for out-of-range (so the error path always completes).
- Apply: when `pending[i]` and (enabled and `cnt == div_act-1`) or channel disabled:
  - `div_act <= shadow_div`, `high_act <= shadow_high`, `pending[i] <= 0`;
  - `cnt` follows normal wrap to 0.
- Simultaneous accept and wrap on the same channel: `pending` was 0 before the cycle, so the apply is deferred to the next wrap. The current period ends with the old settings.
- Deasserting `enable` mid-period truncates the period. Reasserting restarts at `cnt`=0.
- Reset mid-operation discards pending configs and restores defaults.

## Timing
- Output latency is one cycle. With `enable` sampled high at edge k and `cnt`=0, `clock_out` and `tick` go high after edge k.
- Period is exactly `div_act` cycles. High time is exactly `high_act` cycles. `tick` is high 1 cycle per period, coincident with the first high cycle.
- A new config becomes visible at the first output cycle of the period following the apply edge. No partial periods occur while enabled.
- `cfg_err` is high in the cycle after the rejected handshake.
- `cfg_ready` is low from the cycle after acceptance until the cycle after apply.

## Test plan
- Reset defaults with `DEF_DIV`=10 and `DEF_HIGH`=5 (bench override), `enable`=01 → ch0 shows a period of 10 with 5 high, one tick per period; ch1 `clock_out`=0 and `tick`=0 throughout.
- Config ch0 div=4, high=1 mid-period → current 10-cycle period completes unchanged, then periods of 4 with 1 high. `cfg_ready` is low in between and a second request is stalled.
- Invalid requests: div=1; high=0; high=div=6; `cfg_ch`=5 with NCH=2 → each produces one `cfg_err` pulse and outputs are unchanged.
- Config accepted in the same cycle as the ch0 wrap → the old period repeats once before the new settings appear.
- Disabled ch1 with config div=3, high=2 → pending clears the next cycle. On enable, outputs are high 2 cycles and low 1 from the first edge.
- Assert `rst_n`=0 asynchronously mid-period with a pending config → all outputs go to 0 immediately, and after release the defaults run with no pending config applied.

Source files
------------

// File: rtl/clk_div_multi.sv
// NCH runtime-programmable clock dividers; clock_out/tick are registered, one cycle after the counter state.
// Config is valid/ready; a channel stalls new requests until its pending setting applies at a period boundary.
module clk_div_multi #(
   parameter int NCH      = 2,
   parameter int W        = 28,
   parameter int CHW      = 3,
   parameter int DEF_DIV  = 1000000,
   parameter int DEF_HIGH = 500000
) (
   input  logic           clock_in,
   input  logic           rst_n,
   input  logic [NCH-1:0] enable,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [W-1:0]   cfg_div,
   input  logic [W-1:0]   cfg_high,
   output logic           cfg_err,
   output logic [NCH-1:0] clock_out,
   output logic [NCH-1:0] tick
);

   logic [W-1:0]   cnt_q         [NCH];
   logic [W-1:0]   cnt_d         [NCH];
   logic [W-1:0]   div_act_q     [NCH];
   logic [W-1:0]   div_act_d     [NCH];
   logic [W-1:0]   high_act_q    [NCH];
   logic [W-1:0]   high_act_d    [NCH];
   logic [W-1:0]   shadow_div_q  [NCH];
   logic [W-1:0]   shadow_div_d  [NCH];
   logic [W-1:0]   shadow_high_q [NCH];
   logic [W-1:0]   shadow_high_d [NCH];
   logic [NCH-1:0] pending_q, pending_d;
   logic [NCH-1:0] clock_out_q, clock_out_d;
   logic [NCH-1:0] tick_q, tick_d;
   logic           cfg_err_q, cfg_err_d;

   logic [NCH-1:0] ch_hit;
   logic [NCH-1:0] wrap;
   logic           cfg_acc;
   logic           cfg_bad;

   // Out-of-range channels hit nothing, so ready stays high and the error path completes.
   always_comb begin
      ch_hit = '0;
      wrap   = '0;
      for (int i = 0; i < NCH; i++) begin
         ch_hit[i] = (cfg_ch == CHW'(i));
         wrap[i]   = (cnt_q[i] == div_act_q[i] - W'(1));
      end
      cfg_ready = ~|(ch_hit & pending_q);
      cfg_acc   = cfg_valid & cfg_ready;
      cfg_bad   = ~|ch_hit || (cfg_div < W'(2)) || (cfg_high == '0) || (cfg_high >= cfg_div);
   end

   always_comb begin
      cnt_d         = cnt_q;
      div_act_d     = div_act_q;
      high_act_d    = high_act_q;
      shadow_div_d  = shadow_div_q;
      shadow_high_d = shadow_high_q;
      pending_d     = pending_q;
      clock_out_d   = '0;
      tick_d        = '0;
      cfg_err_d     = cfg_acc & cfg_bad;
      for (int i = 0; i < NCH; i++) begin
         if (enable[i]) begin
            clock_out_d[i] = (cnt_q[i] < high_act_q[i]);
            tick_d[i]      = (cnt_q[i] == '0);
            cnt_d[i]       = wrap[i] ? '0 : cnt_q[i] + W'(1);
         end else begin
            cnt_d[i] = '0;
         end
         // Apply only at the end of a period (or any time while stopped), never mid-period.
         if (pending_q[i] && (enable[i] ? wrap[i] : 1'b1)) begin
            div_act_d[i]  = shadow_div_q[i];
            high_act_d[i] = shadow_high_q[i];
            pending_d[i]  = 1'b0;
         end
         if (cfg_acc && !cfg_bad && ch_hit[i]) begin
            shadow_div_d[i]  = cfg_div;
            shadow_high_d[i] = cfg_high;
            pending_d[i]     = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]         <= '0;
            div_act_q[i]     <= W'(DEF_DIV);
            high_act_q[i]    <= W'(DEF_HIGH);
            shadow_div_q[i]  <= '0;
            shadow_high_q[i] <= '0;
         end
         pending_q   <= '0;
         clock_out_q <= '0;
         tick_q      <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         div_act_q     <= div_act_d;
         high_act_q    <= high_act_d;
         shadow_div_q  <= shadow_div_d;
         shadow_high_q <= shadow_high_d;
         pending_q     <= pending_d;
         clock_out_q   <= clock_out_d;
         tick_q        <= tick_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign clock_out = clock_out_q;
   assign tick      = tick_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_DIV=10, DEF_HIGH=5; outputs are recorded at every
// falling edge and compared against hand-specified waveforms built from (div, high, periods).
module tb_clk_div_multi;
   localparam int NCH = 2;
   localparam int W   = 28;
   localparam int CHW = 3;

   logic           clock_in = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] enable;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [W-1:0]   cfg_div;
   logic [W-1:0]   cfg_high;
   logic           cfg_err;
   logic [NCH-1:0] clock_out;
   logic [NCH-1:0] tick;

   int errors = 0;
   int checks = 0;

   // rec[n] = {tick[1], clock_out[1], tick[0], clock_out[0]} sampled after rising edge n
   logic [3:0] rec [0:1023];
   logic [9:0] cyc;

   localparam logic [1:0] CO0 = 2'd0, TK0 = 2'd1, CO1 = 2'd2, TK1 = 2'd3;

   always #5 clock_in = ~clock_in;

   clk_div_multi #(
      .NCH(NCH), .W(W), .CHW(CHW), .DEF_DIV(10), .DEF_HIGH(5)
   ) dut (
      .clock_in (clock_in),
      .rst_n    (rst_n),
      .enable   (enable),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .cfg_err  (cfg_err),
      .clock_out(clock_out),
      .tick     (tick)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clock_in);
      cyc = cyc + 10'd1;
      rec[cyc] = {tick[1], clock_out[1], tick[0], clock_out[0]};
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic cfg_req(input logic [CHW-1:0] ch, input logic [W-1:0] d, input logic [W-1:0] h);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_div   = d;
      cfg_high  = h;
   endtask

   // Expected waveform: n0 periods of (d0,h0) followed by n1 periods of (d1,h1); bit 0 first.
   function automatic logic [127:0] wave(input bit tk, input int d0, input int h0, input int n0,
                                         input int d1, input int h1, input int n1);
      logic [127:0] v;
      logic [6:0]   k;
      v = '0;
      k = '0;
      for (int p = 0; p < n0; p++)
         for (int c = 0; c < d0; c++) begin
            v[k] = tk ? (c == 0) : (c < h0);
            k = k + 7'd1;
         end
      for (int p = 0; p < n1; p++)
         for (int c = 0; c < d1; c++) begin
            v[k] = tk ? (c == 0) : (c < h1);
            k = k + 7'd1;
         end
      return v;
   endfunction

   function automatic logic [127:0] seg(input logic [1:0] sel, input int from, input int n);
      logic [127:0] v;
      logic [9:0]   idx;
      v = '0;
      for (int i = 0; i < n; i++) begin
         idx = 10'(from + i);
         v[i[6:0]] = rec[idx][sel];
      end
      return v;
   endfunction

   initial begin
      rst_n     = 1'b0;
      enable    = '0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_high  = '0;
      cyc       = '0;
      steps(3);
      check("reset_clock_out", 128'(clock_out), 128'(0));
      check("reset_tick", 128'(tick), 128'(0));
      check("reset_cfg_err", 128'(cfg_err), 128'(0));
      check("reset_cfg_ready", 128'(cfg_ready), 128'(1));

      // Defaults on ch0 only
      rst_n  = 1'b1;
      enable = 2'b01;
      cyc    = '0;
      steps(20);
      check("def_ch0_clk", seg(CO0, 1, 20), wave(0, 10, 5, 2, 0, 0, 0));
      check("def_ch0_tick", seg(TK0, 1, 20), wave(1, 10, 5, 2, 0, 0, 0));

      // Mid-period reconfig of ch0; a second request stalls while the first is pending
      steps(3);
      cfg_req(3'd0, 28'd4, 28'd1);
      #1 check("cfg1_ready_before", 128'(cfg_ready), 128'(1));
      step();
      cfg_req(3'd0, 28'd6, 28'd3);
      #1 check("cfg1_stall_a", 128'(cfg_ready), 128'(0));
      steps(2);
      #1 check("cfg1_stall_b", 128'(cfg_ready), 128'(0));
      cfg_valid = 1'b0;
      cfg_div   = 28'd4;
      cfg_high  = 28'd1;
      steps(3);
      #1 check("cfg1_ready_pending", 128'(cfg_ready), 128'(0));
      step();
      #1 check("cfg1_ready_applied", 128'(cfg_ready), 128'(1));
      steps(12);
      check("cfg1_clk", seg(CO0, 21, 22), wave(0, 10, 5, 1, 4, 1, 3));
      check("cfg1_tick", seg(TK0, 21, 22), wave(1, 10, 5, 1, 4, 1, 3));

      // Rejected requests: each gives a single cfg_err pulse
      for (int k = 0; k < 4; k++) begin
         case (k)
            0:       cfg_req(3'd0, 28'd1, 28'd1);
            1:       cfg_req(3'd0, 28'd6, 28'd0);
            2:       cfg_req(3'd0, 28'd6, 28'd6);
            default: cfg_req(3'd5, 28'd4, 28'd2);
         endcase
         #1 check($sformatf("bad%0d_ready", k), 128'(cfg_ready), 128'(1));
         step();
         cfg_valid = 1'b0;
         check($sformatf("bad%0d_err_pulse", k), 128'(cfg_err), 128'(1));
         step();
         check($sformatf("bad%0d_err_clear", k), 128'(cfg_err), 128'(0));
      end
      cfg_ch = 3'd0;
      #1 check("bad_no_pending", 128'(cfg_ready), 128'(1));
      steps(8);
      check("bad_clk_unchanged", seg(CO0, 43, 16), wave(0, 4, 1, 4, 0, 0, 0));
      check("bad_tick_unchanged", seg(TK0, 43, 16), wave(1, 4, 1, 4, 0, 0, 0));

      // Accept on the same edge as a ch0 wrap: old period repeats once more
      steps(3);
      cfg_req(3'd0, 28'd6, 28'd3);
      #1 check("wrapcfg_ready_before", 128'(cfg_ready), 128'(1));
      step();
      cfg_valid = 1'b0;
      #1 check("wrapcfg_ready_pending", 128'(cfg_ready), 128'(0));
      steps(3);
      #1 check("wrapcfg_ready_still", 128'(cfg_ready), 128'(0));
      step();
      #1 check("wrapcfg_ready_applied", 128'(cfg_ready), 128'(1));
      steps(18);
      check("wrapcfg_clk", seg(CO0, 59, 26), wave(0, 4, 1, 2, 6, 3, 3));
      check("wrapcfg_tick", seg(TK0, 59, 26), wave(1, 4, 1, 2, 6, 3, 3));

      // Config to disabled ch1 applies on the next edge; enable starts it from cnt=0
      step();
      cfg_req(3'd1, 28'd3, 28'd2);
      #1 check("ch1_ready_before", 128'(cfg_ready), 128'(1));
      step();
      cfg_valid = 1'b0;
      #1 check("ch1_ready_pending", 128'(cfg_ready), 128'(0));
      step();
      #1 check("ch1_ready_applied", 128'(cfg_ready), 128'(1));
      step();
      enable = 2'b11;
      steps(10);

      // Pending ch0 config, then async reset mid-period
      cfg_req(3'd0, 28'd4, 28'd2);
      step();
      cfg_valid = 1'b0;
      cfg_ch    = 3'd0;
      #1 check("rst_pre_pending", 128'(cfg_ready), 128'(0));
      check("rst_pre_clk_high", 128'(clock_out), 128'(2'b11));
      check("ch0_clk_run", seg(CO0, 85, 12), wave(0, 6, 3, 2, 0, 0, 0));
      check("ch1_clk_run", seg(CO1, 89, 9), wave(0, 3, 2, 3, 0, 0, 0));
      check("ch1_tick_run", seg(TK1, 89, 9), wave(1, 3, 2, 3, 0, 0, 0));
      check("ch1_clk_idle", seg(CO1, 1, 88), 128'(0));
      check("ch1_tick_idle", seg(TK1, 1, 88), 128'(0));
      #2 rst_n = 1'b0;
      #1 check("rst_async_clk", 128'(clock_out), 128'(0));
      check("rst_async_tick", 128'(tick), 128'(0));
      check("rst_async_ready", 128'(cfg_ready), 128'(1));
      steps(2);
      rst_n = 1'b1;
      cyc   = '0;
      steps(20);
      check("post_rst_ch0_clk", seg(CO0, 1, 20), wave(0, 10, 5, 2, 0, 0, 0));
      check("post_rst_ch0_tick", seg(TK0, 1, 20), wave(1, 10, 5, 2, 0, 0, 0));
      check("post_rst_ch1_clk", seg(CO1, 1, 20), wave(0, 10, 5, 2, 0, 0, 0));
      check("post_rst_ch1_tick", seg(TK1, 1, 20), wave(1, 10, 5, 2, 0, 0, 0));
      #1 check("post_rst_ready", 128'(cfg_ready), 128'(1));
      check("post_rst_err", 128'(cfg_err), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
